// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the datapath ALU: sweeps opcodes 0..9 with
// LFSR operands and compacts the ALU responses into a 32-bit MISR signature.
module alu_bist #(
    parameter int unsigned N_VECTORS  = 64,
    parameter logic [31:0] SEED_A     = 32'h1234_5678,
    parameter logic [31:0] SEED_B     = 32'h9ABC_DEF1,
    parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
    localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
    localparam logic [31:0] LFSR_POLY  = 32'h0040_0007;
    localparam logic [15:0] LAST_VEC   = 16'(N_VECTORS - 1);
    localparam logic [3:0]  LAST_OP    = 4'd9;

    state_t      state_q, state_d;
    logic [31:0] lfsr_a_q, lfsr_a_d;
    logic [31:0] lfsr_b_q, lfsr_b_d;
    logic [31:0] misr_q, misr_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;

    always_comb begin
        state_d  = state_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        misr_d   = misr_q;
        op_d     = op_q;
        vec_d    = vec_q;
        pass_d   = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    lfsr_a_d = SEED_A_EFF;
                    lfsr_b_d = SEED_B_EFF;
                    misr_d   = 32'h0;
                    op_d     = 4'd0;
                    vec_d    = 16'd0;
                    pass_d   = 1'b0;
                end
            end
            RUN: begin
                misr_d   = {misr_q[30:0], misr_q[31] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0]}
                           ^ alu_result ^ {31'b0, alu_zero};
                lfsr_a_d = (lfsr_a_q << 1) ^ (lfsr_a_q[31] ? LFSR_POLY : 32'h0);
                lfsr_b_d = (lfsr_b_q << 1) ^ (lfsr_b_q[31] ? LFSR_POLY : 32'h0);
                if (vec_q == LAST_VEC) begin
                    vec_d = 16'd0;
                    if (op_q == LAST_OP) state_d = CHECK;
                    else                 op_d    = op_q + 4'd1;
                end else begin
                    vec_d = vec_q + 16'd1;
                end
            end
            CHECK: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d   = (state_d == RUN) || (state_d == CHECK);
        done_d   = (state_d == DONE);
        alu_a_d  = (state_d == RUN) ? lfsr_a_d : 32'h0;
        alu_b_d  = (state_d == RUN) ? lfsr_b_d : 32'h0;
        alu_op_d = (state_d == RUN) ? op_d     : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_a_q <= 32'h0;
            lfsr_b_q <= 32'h0;
            misr_q   <= 32'h0;
            op_q     <= 4'd0;
            vec_q    <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            alu_a_q  <= 32'h0;
            alu_b_q  <= 32'h0;
            alu_op_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            misr_q   <= misr_d;
            op_q     <= op_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_bist.sv
// Testbench for alu_bist: two instances (N_VECTORS 1 and 3) wired to a
// behavioural ALU, checked against a reference signature model.
module tb_alu_bist;

    localparam logic [31:0] SA = 32'h1234_5678;
    localparam logic [31:0] SB = 32'h9ABC_DEF1;

    function automatic logic [31:0] lfsrNext(logic [31:0] q);
        return (q << 1) ^ (q[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    function automatic logic [31:0] misrNext(logic [31:0] m, logic [31:0] res, logic z);
        return {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ res ^ {31'b0, z};
    endfunction

    // Reference ALU: returns {zero, result}.
    function automatic logic [32:0] aluModel(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $signed(a) >>> b[4:0];
            4'd8:    r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            4'd9:    r = (a < b) ? 32'h1 : 32'h0;
            default: r = 32'h0;
        endcase
        return {(r == 32'h0), r};
    endfunction

    // Expected final signature of a whole sweep; faultIdx flips result bit 0
    // for that vector index (negative means no fault).
    function automatic logic [31:0] refSig(int n, int faultIdx);
        logic [31:0] a, b, m, res;
        logic [32:0] r;
        int idx;
        a = SA; b = SB; m = 32'h0; idx = 0;
        for (int op = 0; op < 10; op++) begin
            for (int v = 0; v < n; v++) begin
                r = aluModel(a, b, 4'(op));
                res = r[31:0];
                if (idx == faultIdx) res = res ^ 32'h1;
                m = misrNext(m, res, r[32]);
                a = lfsrNext(a);
                b = lfsrNext(b);
                idx++;
            end
        end
        return m;
    endfunction

    localparam logic [31:0] GOLD1 = refSig(1, -1);
    localparam logic [31:0] GOLD3 = refSig(3, -1);

    logic        clk, rst_n;
    logic        start1, start2, flip1;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [31:0] sig1, a1, b1, res1, sig2, a2, b2, res2;
    logic [3:0]  op1, op2;
    logic [32:0] r1, r2;
    logic        zero1, zero2;

    assign r1    = aluModel(a1, b1, op1);
    assign res1  = r1[31:0] ^ {31'b0, flip1};
    assign zero1 = r1[32];
    assign r2    = aluModel(a2, b2, op2);
    assign res2  = r2[31:0];
    assign zero2 = r2[32];

    alu_bist #(.N_VECTORS(1), .SEED_A(SA), .SEED_B(SB), .GOLDEN_SIG(GOLD1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .signature(sig1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
        .alu_result(res1), .alu_zero(zero1)
    );

    alu_bist #(.N_VECTORS(3), .SEED_A(SA), .SEED_B(SB), .GOLDEN_SIG(GOLD3 ^ 32'h1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .pass(pass2), .signature(sig2), .alu_a(a2), .alu_b(b2), .alu_op(op2),
        .alu_result(res2), .alu_zero(zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(int which);
        if (which == 1) start1 = 1'b1;
        else            start2 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        logic [31:0] ea, eb, em;
        logic [32:0] r;
        int j, m, cyc;

        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; flip1 = 1'b0;
        tick(); tick();
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", done1, 0);
        checkOutput("rst_pass", pass1, 0);
        checkOutput("rst_a", a1, 0);
        checkOutput("rst_b", b1, 0);
        checkOutput("rst_op", op1, 0);
        checkOutput("rst_sig", sig1, 0);
        checkOutput("rst_sig2", sig2, 0);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 4)) tick();

        // Clean sweep with cycle-by-cycle bus and signature tracking.
        applyStimulus(1);
        ea = SA; eb = SB; em = 32'h0;
        for (int c = 0; c < 10; c++) begin
            checkOutput("seq_op", op1, c);
            checkOutput("seq_a", a1, ea);
            checkOutput("seq_b", b1, eb);
            checkOutput("seq_sig", sig1, em);
            checkOutput("seq_busy", busy1, 1);
            checkOutput("seq_done", done1, 0);
            r  = aluModel(ea, eb, 4'(c));
            em = misrNext(em, r[31:0], r[32]);
            ea = lfsrNext(ea);
            eb = lfsrNext(eb);
            tick();
        end
        checkOutput("chk_busy", busy1, 1);
        checkOutput("chk_done", done1, 0);
        checkOutput("chk_op", op1, 0);
        checkOutput("chk_sig", sig1, em);
        tick();
        checkOutput("fin_done", done1, 1);
        checkOutput("fin_busy", busy1, 0);
        checkOutput("fin_pass", pass1, 1);
        checkOutput("fin_sig", sig1, GOLD1);
        checkOutput("fin_a", a1, 0);
        repeat ($urandom_range(0, 3)) tick();
        checkOutput("hold_sig", sig1, GOLD1);
        checkOutput("hold_done", done1, 1);

        // Restart from DONE with a single-cycle fault on result bit 0.
        j = $urandom_range(0, 9);
        applyStimulus(1);
        checkOutput("restart_done", done1, 0);
        checkOutput("restart_a", a1, SA);
        for (int i = 0; i < 10; i++) begin
            flip1 = (i == j);
            tick();
        end
        flip1 = 1'b0;
        tick();
        checkOutput("fault_done", done1, 1);
        checkOutput("fault_sig", sig1, refSig(1, j));
        checkOutput("fault_differs", (sig1 != GOLD1), 1);
        checkOutput("fault_pass", pass1, 0);

        // Start pulse during RUN must be ignored.
        m = $urandom_range(1, 8);
        applyStimulus(1);
        for (int i = 0; i < 10; i++) begin
            start1 = (i == m);
            tick();
        end
        start1 = 1'b0;
        checkOutput("ign_done_early", done1, 0);
        checkOutput("ign_op", op1, 0);
        tick();
        checkOutput("ign_done", done1, 1);
        checkOutput("ign_sig", sig1, GOLD1);
        checkOutput("ign_pass", pass1, 1);

        // Reset in the middle of a longer run.
        applyStimulus(2);
        checkOutput("n3_a", a2, SA);
        repeat ($urandom_range(1, 25)) tick();
        checkOutput("mid_busy_pre", busy2, 1);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_busy", busy2, 0);
        checkOutput("mid_done", done2, 0);
        checkOutput("mid_pass", pass2, 0);
        checkOutput("mid_sig", sig2, 0);
        checkOutput("mid_a", a2, 0);
        checkOutput("mid_b", b2, 0);
        checkOutput("mid_op", op2, 0);
        checkOutput("mid_done1", done1, 0);
        rst_n = 1'b1;
        tick();

        // Full run after reset; golden is deliberately off by one bit.
        applyStimulus(2);
        cyc = 1;
        while (!done2 && cyc < 100) begin
            tick();
            cyc++;
        end
        checkOutput("n3_latency", cyc, 32);
        checkOutput("n3_sig", sig2, GOLD3);
        checkOutput("n3_pass", pass2, 0);
        checkOutput("n3_busy", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer for the datapath ALU. It drives operands and opcodes into the ALU and reads back `Result` and `Zero`. It sweeps every defined opcode, 0 through 9, using pseudo-random operands from two LFSRs, and compacts the responses into a 32-bit MISR signature. At the end it compares that signature against a golden value. It sits beside the ALU behind the operand muxes and is selected while `busy` is high.

## Interface

Parameters:
- `N_VECTORS`, default 64: operand vectors applied per opcode. Legal range is 1 to 65535.
- `SEED_A`, default 32'h1234_5678: LFSR-A seed. A value of 0 is replaced by 32'h1.
- `SEED_B`, default 32'h9ABC_DEF1: LFSR-B seed. A value of 0 is replaced by 32'h1.
- `GOLDEN_SIG`, default 32'h0000_0000: expected final signature.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begins a test. Sampled only in IDLE or DONE.
- `busy`, out, 1: high in RUN and CHECK.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: signature matched. Valid while `done` is high.
- `signature`, out, 32: current MISR value.
- `alu_a`, out, 32: ALU operand A.
- `alu_b`, out, 32: ALU operand B.
- `alu_op`, out, 4: ALU opcode.
- `alu_result`, in, 32: ALU result. The ALU is combinational, so this is valid in the same cycle.
- `alu_zero`, in, 1: ALU zero flag.

## Operation

- The FSM has four states: IDLE, RUN, CHECK, DONE.
- All outputs are registered.
- In IDLE, CHECK and DONE: `alu_a`, `alu_b` and `alu_op` are 0.
- Reset, applied in any state including mid-RUN, forces:
  - state to IDLE;
  - `busy`, `done` and `pass` to 0;
  - `signature`, both LFSRs, the opcode counter and the vector counter to 0.
- Start from IDLE or DONE (`start` = 1):
  - load LFSR-A with `SEED_A` and LFSR-B with `SEED_B`;
  - clear the opcode counter, the vector counter and the MISR;
  - clear `done` and `pass`;
  - go to RUN.
- RUN, every cycle:
  - the ALU is presented with `alu_a` = LFSR-A, `alu_b` = LFSR-B, `alu_op` = opcode counter;
  - on the clock edge, the MISR absorbs the response (update rule below);
  - on the same edge, both LFSRs step.
- Counters in RUN:
  - the vector counter counts 0 to N_VECTORS-1, then wraps to 0 and increments the opcode counter;
  - when the opcode counter is 9 and the vector counter is N_VECTORS-1, the FSM goes to CHECK.
- LFSR step (Galois, x^32+x^22+x^2+x+1): next = (q << 1) ^ (q[31] ? 32'h0040_0007 : 0).
- MISR update: next = {m[30:0], m[31]^m[21]^m[1]^m[0]} ^ `alu_result` ^ {31'b0, `alu_zero`}.
- CHECK lasts one cycle: `pass` <= (MISR == `GOLDEN_SIG`), `done` <= 1, then go to DONE.
- DONE holds `done`, `pass` and `signature` until the next `start` or reset.
- `start` is ignored in RUN and CHECK.
- Opcodes 10 to 15 are never issued.

## Timing

- If `start` is sampled at edge k:
  - `busy` = 1 and the first vector is on the ALU bus during cycle k+1;
  - RUN covers cycles k+1 through k+10·N_VECTORS;
  - CHECK is cycle k+10·N_VECTORS+1;
  - `done` = 1 from cycle k+10·N_VECTORS+2.
- Total latency from start to done is 10·N_VECTORS + 2 cycles.
- `signature` updates once per RUN cycle and is frozen in CHECK and DONE.
- A restart from DONE drops `done` in the cycle after `start` is sampled.

## Test plan

- **Reset:** hold `rst_n` = 0 for 2 cycles. Required: `busy` = `done` = `pass` = 0; `alu_a` = `alu_b` = 0; `alu_op` = 0; `signature` = 0.
- **Sequence check:** N_VECTORS = 1, `start` pulse, connected to a real ALU model. Required:
  - cycle 1 shows `alu_a` = 32'h1234_5678, `alu_b` = 32'h9ABC_DEF1, `alu_op` = 0;
  - cycle 2 shows `alu_a` = 32'h2468_ACF0, `alu_op` = 1;
  - `alu_op` runs 0 through 9, one value per cycle;
  - `done` rises exactly 12 cycles after `start` is sampled.
- **Golden match:** record `signature` from a clean run, rebuild with that value as GOLDEN_SIG, rerun. Required: `pass` = 1. With GOLDEN_SIG XOR 1: `pass` = 0.
- **Fault injection:** flip `alu_result` bit 0 for one RUN cycle. Required: final signature differs from golden, and `pass` = 0.
- **Start ignored:** pulse `start` mid-RUN. Required: no restart, same completion cycle, same signature.
- **Reset mid-run:** deassert `rst_n` mid-RUN. Required: IDLE with all outputs 0 on the next cycle. A subsequent full run reproduces the golden signature.
